// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results with buffered multi-cycle
// results into the single regfile write port and tracks pending rds.
package rv32ima_pkg;
  typedef logic [4:0]  reg_t;
  typedef logic [31:0] word_t;
endpackage

module wb_arbiter
  import rv32ima_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pri_valid,
  input  reg_t        pri_rd,
  input  word_t       pri_data,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  reg_t        sec_rd,
  input  word_t       sec_data,
  input  logic        claim_en,
  input  reg_t        claim_rd,
  input  reg_t        q_rs1,
  input  reg_t        q_rs2,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        drain_req,
  output logic [31:0] pending,
  output logic        wen,
  output reg_t        wsel,
  output word_t       wdat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  reg_t          mem_rd  [DEPTH];
  word_t         mem_dat [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;

  logic  push;
  logic  pop;
  logic  src_sec;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] pend_next;

  // Acceptance depends on occupancy only, never on a same-cycle pop
  always_comb begin
    sec_ready = !rst && (count < FULL);
    drain_req = (count == FULL);
    push      = sec_valid && sec_ready;
    pop       = !pri_valid && (count != '0);
  end

  // Scoreboard update: retire secondary writes, then apply new claims
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wen && src_sec)
      clr_mask = 32'(1) << wsel;
    if (claim_en && claim_rd != '0)
      set_mask = 32'(1) << claim_rd;
    pend_next = ((pending & ~clr_mask) | set_mask)
              & ~32'd1;
  end

  // Query ports read the scoreboard directly
  always_comb begin
    busy_rs1 = pending[q_rs1];
    busy_rs2 = pending[q_rs2];
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wp]  <= sec_rd;
      mem_dat[wp] <= sec_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Write port: primary has strict priority over the FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      wen     <= 1'b0;
      wsel    <= '0;
      wdat    <= '0;
      src_sec <= 1'b0;
    end else if (pri_valid) begin
      wen     <= (pri_rd != '0);
      wsel    <= pri_rd;
      wdat    <= pri_data;
      src_sec <= 1'b0;
    end else if (pop) begin
      wen     <= (mem_rd[rp] != '0);
      wsel    <= mem_rd[rp];
      wdat    <= mem_dat[rp];
      src_sec <= 1'b1;
    end else begin
      wen     <= 1'b0;
      src_sec <= 1'b0;
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pend_next;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pri_valid = 1'b0;
  logic [4:0]  pri_rd = '0;
  logic [31:0] pri_data = '0;
  logic        sec_valid = 1'b0;
  logic        sec_ready;
  logic [4:0]  sec_rd = '0;
  logic [31:0] sec_data = '0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_rd = '0;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        drain_req;
  logic [31:0] pending;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdat;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pri_valid(pri_valid), .pri_rd(pri_rd), .pri_data(pri_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready),
    .sec_rd(sec_rd), .sec_data(sec_data),
    .claim_en(claim_en), .claim_rd(claim_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .drain_req(drain_req), .pending(pending),
    .wen(wen), .wsel(wsel), .wdat(wdat)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of results and a set of pending registers.
  logic [36:0] mq[$];
  logic        m_wen = 1'b0;
  logic [4:0]  m_wsel = '0;
  logic [31:0] m_wdat = '0;
  logic        m_src = 1'b0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    logic [36:0] e;
    logic        was_full;
    logic        ret_sec;
    logic [4:0]  ret_rd;
    if (rst) begin
      mq.delete();
      m_wen = 1'b0; m_wsel = '0; m_wdat = '0;
      m_src = 1'b0; m_pend = '0;
    end else begin
      ret_sec = m_wen && m_src;
      ret_rd = m_wsel;
      was_full = (mq.size() == DEPTH);
      if (pri_valid) begin
        m_wen = (pri_rd != 0); m_wsel = pri_rd;
        m_wdat = pri_data; m_src = 1'b0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wsel = e[36:32]; m_wdat = e[31:0];
        m_wen = (m_wsel != 0); m_src = 1'b1;
      end else begin
        m_wen = 1'b0; m_src = 1'b0;
      end
      if (sec_valid && !was_full)
        mq.push_back({sec_rd, sec_data});
      if (ret_sec) m_pend[ret_rd] = 1'b0;
      if (claim_en) m_pend[claim_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pri_valid = 0; sec_valid = 0; claim_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; sec_valid = 1; sec_rd = 5'd3; sec_data = 32'h55;
    for (int i = 0; i < 2; i++) begin
      cyc(); #3;
      total_cnt++;
      if (sec_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", sec_ready);
      else pass_cnt++;
      total_cnt++;
      if (wen !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", wen);
      else pass_cnt++;
      total_cnt++;
      if (pending !== 32'h0) $display("FAIL reset_pending got=%h exp=0", pending);
      else pass_cnt++;
    end
    idle();
    rst = 0; #1;
    total_cnt++;
    if (sec_ready !== 1'b1) $display("FAIL release_ready got=%0b exp=1", sec_ready);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_primary();
    pri_valid = 1; pri_rd = 5'd5; pri_data = 32'hDEADBEEF;
    cyc();
    pri_rd = 5'd0; pri_data = 32'h11111111;
    #3;
    total_cnt++;
    if (wen !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF)
      $display("FAIL pri_write got=%0b/%0d/%h exp=1/5/deadbeef", wen, wsel, wdat);
    else pass_cnt++;
    cyc();
    idle(); #3;
    total_cnt++;
    if (wen !== 1'b0) $display("FAIL pri_x0 got=%0b exp=0", wen);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_claim_clear();
    claim_en = 1; claim_rd = 5'd7; q_rs1 = 5'd7;
    cyc();
    claim_en = 0; #3;
    total_cnt++;
    if (busy_rs1 !== 1'b1) $display("FAIL claim_busy got=%0b exp=1", busy_rs1);
    else pass_cnt++;
    cyc();
    sec_valid = 1; sec_rd = 5'd7; sec_data = 32'h12;
    cyc();
    sec_valid = 0; #3;
    total_cnt++;
    if (wen !== 1'b0 || busy_rs1 !== 1'b1)
      $display("FAIL sec_m1 got=%0b/%0b exp=0/1", wen, busy_rs1);
    else pass_cnt++;
    cyc(); #3;
    total_cnt++;
    if (wen !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h12)
      $display("FAIL sec_m2 got=%0b/%0d/%h exp=1/7/12", wen, wsel, wdat);
    else pass_cnt++;
    total_cnt++;
    if (busy_rs1 !== 1'b1) $display("FAIL sec_m2_busy got=%0b exp=1", busy_rs1);
    else pass_cnt++;
    cyc(); #3;
    total_cnt++;
    if (busy_rs1 !== 1'b0) $display("FAIL sec_m3_busy got=%0b exp=0", busy_rs1);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_priority_full();
    logic [4:0]  er[5];
    logic [31:0] ed[5];
    er = '{5'd10, 5'd11, 5'd12, 5'd3, 5'd4};
    ed = '{32'd100, 32'd101, 32'd102, 32'hA, 32'hB};
    for (int i = 0; i < 3; i++) begin
      pri_valid = 1; pri_rd = er[i]; pri_data = ed[i];
      sec_valid = 1;
      sec_rd = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd20;
      sec_data = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hEE;
      #3;
      if (i == 2) begin
        total_cnt++;
        if (drain_req !== 1'b1 || sec_ready !== 1'b0)
          $display("FAIL full_flags got=%0b/%0b exp=1/0", drain_req, sec_ready);
        else pass_cnt++;
      end
      if (i > 0) begin
        total_cnt++;
        if (wen !== 1'b1 || wsel !== er[i-1] || wdat !== ed[i-1])
          $display("FAIL prio_%0d got=%0b/%0d/%h exp=1/%0d/%h",
                   i - 1, wen, wsel, wdat, er[i-1], ed[i-1]);
        else pass_cnt++;
      end
      cyc();
    end
    idle();
    for (int k = 2; k < 5; k++) begin
      #3;
      total_cnt++;
      if (wen !== 1'b1 || wsel !== er[k] || wdat !== ed[k])
        $display("FAIL prio_%0d got=%0b/%0d/%h exp=1/%0d/%h",
                 k, wen, wsel, wdat, er[k], ed[k]);
      else pass_cnt++;
      cyc();
    end
    #3;
    total_cnt++;
    if (wen !== 1'b0 || drain_req !== 1'b0)
      $display("FAIL prio_drained got=%0b/%0b exp=0/0", wen, drain_req);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_simul();
    claim_en = 1; claim_rd = 5'd9; q_rs2 = 5'd9;
    cyc();
    claim_en = 0;
    sec_valid = 1; sec_rd = 5'd9; sec_data = 32'h99;
    cyc();
    sec_valid = 0;
    cyc();
    claim_en = 1; claim_rd = 5'd9; #3;
    total_cnt++;
    if (wen !== 1'b1 || wsel !== 5'd9)
      $display("FAIL simul_retire got=%0b/%0d exp=1/9", wen, wsel);
    else pass_cnt++;
    cyc();
    claim_en = 0; #3;
    total_cnt++;
    if (pending[9] !== 1'b1 || busy_rs2 !== 1'b1)
      $display("FAIL simul_set_wins got=%0b/%0b exp=1/1", pending[9], busy_rs2);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      claim_en = 1; claim_rd = 5'(i + 1);
      pri_valid = 1; pri_rd = 5'd20; pri_data = 32'(i);
      sec_valid = (i < 2); sec_rd = 5'(i + 1); sec_data = 32'hF00 + 32'(i);
      cyc();
    end
    idle(); #3;
    total_cnt++;
    if (drain_req !== 1'b1 || pending[3:1] !== 3'b111)
      $display("FAIL mid_pre got=%0b/%b exp=1/111", drain_req, pending[3:1]);
    else pass_cnt++;
    rst = 1;
    cyc();
    rst = 0; #3;
    total_cnt++;
    if (pending !== 32'h0 || drain_req !== 1'b0 || sec_ready !== 1'b1)
      $display("FAIL mid_post got=%h/%0b/%0b exp=0/0/1", pending, drain_req, sec_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (wen !== 1'b0) $display("FAIL mid_flush_%0d got=%0b exp=0", i, wen);
      else pass_cnt++;
      cyc(); #3;
    end
    cyc();
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      pri_valid = ($urandom_range(0, 9) < 4);
      pri_rd = 5'($urandom_range(0, 7));
      pri_data = $urandom;
      sec_valid = ($urandom_range(0, 9) < 6);
      sec_rd = 5'($urandom_range(0, 7));
      sec_data = $urandom;
      claim_en = ($urandom_range(0, 9) < 3);
      claim_rd = 5'($urandom_range(0, 7));
      q_rs1 = 5'($urandom_range(0, 7));
      q_rs2 = 5'($urandom_range(0, 31));
      #3;
      exp_ready = !rst && (mq.size() < DEPTH);
      total_cnt++;
      if (wen !== m_wen || (m_wen && (wsel !== m_wsel || wdat !== m_wdat)))
        $display("FAIL rnd_write n=%0d got=%0b/%0d/%h exp=%0b/%0d/%h",
                 n, wen, wsel, wdat, m_wen, m_wsel, m_wdat);
      else pass_cnt++;
      total_cnt++;
      if (pending !== m_pend)
        $display("FAIL rnd_pending n=%0d got=%h exp=%h", n, pending, m_pend);
      else pass_cnt++;
      total_cnt++;
      if (sec_ready !== exp_ready || drain_req !== (mq.size() == DEPTH))
        $display("FAIL rnd_flags n=%0d got=%0b/%0b exp=%0b/%0b",
                 n, sec_ready, drain_req, exp_ready, mq.size() == DEPTH);
      else pass_cnt++;
      total_cnt++;
      if (busy_rs1 !== m_pend[q_rs1] || busy_rs2 !== m_pend[q_rs2])
        $display("FAIL rnd_busy n=%0d got=%0b/%0b exp=%0b/%0b",
                 n, busy_rs1, busy_rs2, m_pend[q_rs1], m_pend[q_rs2]);
      else pass_cnt++;
      cyc();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_primary();
    test_claim_clear();
    test_priority_full();
    test_simul();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter directly upstream of the register file write port. Merges the single-cycle pipeline result stream with results from multi-cycle units (MUL/DIV, AMO/LSU) into the register file's one write port (`wen`/`wsel`/`wdat`). Buffers multi-cycle results in a small FIFO and keeps a per-register pending scoreboard that decode queries to stall on outstanding multi-cycle destinations.

## Interface
Parameters:
- `DEPTH`, 2: secondary FIFO entries, power of two, at least 2.

Ports (`reg_t` is 5 bits, `word_t` is 32 bits, both from `rv32ima_pkg`):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pri_valid`  in  1  pipeline result valid; no backpressure.
- `pri_rd`  in  reg_t  pipeline destination.
- `pri_data`  in  word_t  pipeline result.
- `sec_valid`  in  1  multi-cycle result valid.
- `sec_ready`  out  1  FIFO can accept.
- `sec_rd`  in  reg_t  multi-cycle destination.
- `sec_data`  in  word_t  multi-cycle result.
- `claim_en`  in  1  decode issues a multi-cycle op.
- `claim_rd`  in  reg_t  its destination.
- `q_rs1`, `q_rs2`  in  reg_t  decode source query.
- `busy_rs1`, `busy_rs2`  out  1  queried register pending.
- `drain_req`  out  1  FIFO full; decode must insert a bubble.
- `pending`  out  32  scoreboard mask.
- `wen`  out  1  to regfile.
- `wsel`  out  reg_t  to regfile.
- `wdat`  out  word_t  to regfile.

## Operation
- **Reset** (`rst` high at an edge):
  - `wen`=0, `wsel`=0, `wdat`=0, `pending`=0, FIFO empty.
  - `sec_ready`=0 while `rst` is high; otherwise `sec_ready` = (count < `DEPTH`).
  - Reset mid-operation discards FIFO contents and all claims.
- **Secondary accept**: `sec_valid && sec_ready` pushes {`sec_rd`, `sec_data`} at the edge.
  - `sec_ready` depends only on count, so no push occurs when full, even if a pop happens the same cycle.
- **Write selection**, evaluated each cycle:
  - If `pri_valid`: the primary result is registered to the output. The FIFO is not popped.
  - Else if the FIFO is non-empty: pop the head and register it.
  - Else: `wen`=0 next cycle. `wsel`/`wdat` hold their previous values.
- **x0**: a selected entry with rd=0 registers `wen`=0. A popped x0 entry is still consumed.
- **Scoreboard**:
  - Set: `claim_en` with `claim_rd`≠0 sets `pending[claim_rd]` at the edge.
  - Clear: `pending[r]` clears at the edge that ends a cycle with `wen`=1 for a secondary-sourced write to r. This is the same edge at which the regfile commits the write.
  - Set and clear of the same register at the same edge: set wins.
  - Primary writes never touch `pending`.
  - `pending[0]` is always 0.
- **Busy outputs**: `busy_rsN` = `pending[q_rsN]`, combinational.
- **drain_req** = (count == `DEPTH`). The primary stream has strict priority and the block gives no starvation guarantee; decode must bubble when `drain_req` is high.
- **Ordering**: decode never issues a primary write to a pending register. Behaviour is undefined if it does (the later FIFO write overwrites).
- **Count**: `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.

## Timing
- Primary: `pri_valid` in cycle N gives `wen`/`wsel`/`wdat` in cycle N+1. The regfile commits at the end of N+1.
- Secondary, FIFO empty, no primary traffic: accepted in N, popped in N+1, `wen` in N+2. The `pending` bit is cleared at the end of N+2 and `busy` reads 0 from N+3.
- Each cycle of primary traffic delays a queued secondary entry by one cycle.
- Claim in cycle N gives `busy` from N+1.

## Test plan
- **Reset**: hold `rst` 2 cycles with `sec_valid`=1. Required: `sec_ready`=0, `wen`=0, `pending`=0. After release, `sec_ready`=1 in the first cycle.
- **Primary path**: `pri_valid`, rd=5, data=0xDEADBEEF in cycle N. Required: cycle N+1 shows `wen`=1, `wsel`=5, `wdat`=0xDEADBEEF. With rd=0, `wen`=0.
- **Claim/clear**: claim rd=7 in cycle N. Required: `busy_rs1`(q=7)=1 from N+1. Then push sec rd=7, data=0x12 in cycle M with no primary traffic. Required: `wen` in M+2 and `busy`=0 at M+3.
- **Priority and full**: push 2 sec entries (rd=3 data=0xA, rd=4 data=0xB) while `pri_valid` is held 3 cycles. Required: `drain_req`=1 and `sec_ready`=0 while full. The three primary writes land first, then 0xA, then 0xB, in order.
- **Simultaneous set/clear**: claim rd=9 in the same cycle that sec rd=9 retires. Required: `pending[9]` stays 1.
- **Mid-operation reset**: reset with 2 entries queued and 3 claims outstanding. Required: no `wen` from flushed entries, and `pending`=0.
